// File: rtl/imem_boot_loader_if.sv
// Bus bundle for imem_boot_loader: the inbound byte stream (valid/ready)
// and the instruction-memory write port.
//
//   rx_valid   byte-stream valid            (source -> loader)
//   rx_data    byte-stream data, 8 bits     (source -> loader)
//   rx_ready   loader accepts a byte        (loader -> source)
//   imem_we    imem write strobe            (loader -> memory)
//   imem_waddr imem word address            (loader -> memory)
//   imem_wdata imem write data, 32 bits     (loader -> memory)
//
// Modports: slave = the loader, master = the surrounding environment
// (byte source plus instruction memory).
interface imem_boot_loader_if #(
  parameter int ADDR_W = 6
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot sequencer for the single-cycle core.
// Holds the core in reset, receives a program as a byte stream, packs bytes
// into 32-bit little-endian words and writes them to instruction memory at
// word addresses 0, 1, 2, ... Releases core reset once len words are loaded.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   start      one-cycle load request (honoured in IDLE and RUN)
//   len        number of words to load, sampled with an honoured start
//   bus        imem_boot_loader_if.slave: rx_valid/rx_data/rx_ready byte
//              stream and imem_we/imem_waddr/imem_wdata write port
//   core_reset reset to the core, high unless in RUN
//   busy       high in LOAD and FLUSH
//   done       high in RUN
//   error      one-cycle pulse on a rejected start or failed checksum
//
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing
// checksum byte after the program; (sum of all bytes + checksum) mod 256
// must be zero, otherwise the loader returns to IDLE with error.
module imem_boot_loader #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  imem_boot_loader_if.slave bus,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_CHECK
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN
  } state_t;
`endif

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] ONE_W    = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;

  logic [1:0]        byte_cnt;
  // Word counter is one bit wider than the address so len=IMEM_DEPTH never
  // wraps it back to 0 inside a load.
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   last_q;      // address of the final word, len-1
  logic [23:0]       asm_q;       // bytes 0..2 of the word in progress
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              error_q;

  logic              len_ok;
  logic              can_start;
  logic              start_ok;
  logic              start_bad;
  logic              rx_ready_c;
  logic              accept;
  logic              last_wr;
  logic [ADDR_W:0]   len_m1;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
  logic              sum_ok;
  logic              chk_fail;
`endif

  assign len_ok    = (len != '0) && (len <= DEPTH_L);
  assign can_start = (state_q == S_IDLE) || (state_q == S_RUN);
  assign start_ok  = start && can_start && len_ok;
  assign start_bad = start && can_start && !len_ok;
  assign accept    = bus.rx_valid && rx_ready_c;
  assign len_m1    = len - ONE_W;
  // The final write cycle is detected from the registered write itself, so
  // rx_ready can drop in that same cycle.
  assign last_wr   = we_q && ({1'b0, waddr_q} == last_q);

`ifdef LOADER_CHECKSUM_EN
  assign sum_ok   = (sum_q + bus.rx_data) == 8'h00;
  assign chk_fail = (state_q == S_CHECK) && accept && !sum_ok;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
        if (last_wr) state_d = S_CHECK;
`else
        if (last_wr) state_d = S_FLUSH;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = sum_ok ? S_FLUSH : S_IDLE;
      end
`endif
      S_FLUSH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (start_ok) state_d = S_LOAD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    rx_ready_c = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_LOAD: begin
        rx_ready_c = !last_wr;
        busy       = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        rx_ready_c = 1'b1;
      end
`endif
      S_FLUSH: begin
        busy = 1'b1;
      end
      S_RUN: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.rx_ready   = rx_ready_c;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign error          = error_q;

  // Datapath: byte assembly, write port, counters, error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      last_q   <= '0;
      asm_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      we_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      error_q <= start_bad || chk_fail;
`else
      error_q <= start_bad;
`endif
      if (start_ok) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        last_q   <= len_m1;
`ifdef LOADER_CHECKSUM_EN
        sum_q    <= '0;
`endif
      end else if ((state_q == S_LOAD) && accept) begin
        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        sum_q    <= sum_q + bus.rx_data;
`endif
        unique case (byte_cnt)
          2'd0: asm_q[7:0]   <= bus.rx_data;
          2'd1: asm_q[15:8]  <= bus.rx_data;
          2'd2: asm_q[23:16] <= bus.rx_data;
          2'd3: begin
            // Byte 3 goes straight into the write register; the strobe
            // follows one cycle after acceptance.
            we_q     <= 1'b1;
            waddr_q  <= word_cnt[ADDR_W-1:0];
            wdata_q  <= {bus.rx_data, asm_q};
            word_cnt <= word_cnt + ONE_W;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed byte streams with
// hand-computed expected words, write-port scoreboard, reset behaviour,
// invalid-length handling and (when LOADER_CHECKSUM_EN is defined) the
// trailing checksum byte.
module tb_imem_boot_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [ADDR_W:0] len;
  logic            core_reset;
  logic            busy;
  logic            done;
  logic            error;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(
    .IMEM_DEPTH (DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .bus        (bus),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  logic              wq_rdy[$];
  logic [7:0]        run_sum;
  logic [7:0]        prog[$];
  logic [31:0]       exp_w;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and record any write seen there.
  task automatic cyc();
    @(negedge clk);
    if (bus.imem_we === 1'b1) begin
      wq_addr.push_back(bus.imem_waddr);
      wq_data.push_back(bus.imem_wdata);
      wq_rdy.push_back(bus.rx_ready);
    end
  endtask

  task automatic clear_wq();
    wq_addr.delete();
    wq_data.delete();
    wq_rdy.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    logic ok;
    int unsigned n;
    bus.rx_valid = 1'b0;
    repeat (gap) cyc();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (1) begin
      ok = bus.rx_ready;
      cyc();
      if (ok) begin
        run_sum = run_sum + b;
        break;
      end
      n++;
      if (n > 50) begin
        check_eq("rx_ready_timeout", {31'b0, ok}, 32'd1);
        break;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic start_load(input logic [ADDR_W:0] l);
    start   = 1'b1;
    len     = l;
    run_sum = 8'h00;
    cyc();
    start = 1'b0;
    len   = '0;
  endtask

  // From the last data write cycle to the first RUN cycle.
  task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00 - run_sum;
    send_byte(cs, 0);
`else
    cyc();
`endif
    cyc();
  endtask

  task automatic send_prog(input int unsigned max_gap);
    foreach (prog[i]) send_byte(prog[i], (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    len          = '0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    run_sum      = 8'h00;
    cyc();
    cyc();
    check_eq("rst_core_reset", {31'b0, core_reset}, 32'd1);
    check_eq("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    check_eq("rst_imem_we", {31'b0, bus.imem_we}, 32'd0);
    check_eq("rst_waddr", {26'b0, bus.imem_waddr}, 32'd0);
    check_eq("rst_wdata", bus.imem_wdata, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_error", {31'b0, error}, 32'd0);
    reset = 1'b0;

    // Idle with no stimulus
    repeat (5) cyc();
    check_eq("idle_core_reset", {31'b0, core_reset}, 32'd1);
    check_eq("idle_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    check_eq("idle_imem_we", {31'b0, bus.imem_we}, 32'd0);
    check_eq("idle_done", {31'b0, done}, 32'd0);

    // Rejected lengths in IDLE
    start_load(7'd0);
    check_eq("len0_error", {31'b0, error}, 32'd1);
    cyc();
    check_eq("len0_error_clr", {31'b0, error}, 32'd0);
    check_eq("len0_busy", {31'b0, busy}, 32'd0);
    check_eq("len0_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    start_load(7'd65);
    check_eq("len65_error", {31'b0, error}, 32'd1);
    cyc();
    check_eq("len65_error_clr", {31'b0, error}, 32'd0);
    check_eq("len65_busy", {31'b0, busy}, 32'd0);
    check_eq("len65_core_reset", {31'b0, core_reset}, 32'd1);
    check_eq("invalid_no_writes", wq_addr.size(), 32'd0);

    // Two-word program, back-to-back bytes
    clear_wq();
    start_load(7'd2);
    check_eq("l2_busy", {31'b0, busy}, 32'd1);
    check_eq("l2_rx_ready", {31'b0, bus.rx_ready}, 32'd1);
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_prog(0);
    finish_load();
    check_eq("l2_done", {31'b0, done}, 32'd1);
    check_eq("l2_core_reset", {31'b0, core_reset}, 32'd0);
    check_eq("l2_busy_run", {31'b0, busy}, 32'd0);
    check_eq("l2_nwrites", wq_addr.size(), 32'd2);
    if (wq_addr.size() == 2) begin
      check_eq("l2_w0_addr", {26'b0, wq_addr[0]}, 32'd0);
      check_eq("l2_w0_data", wq_data[0], 32'h0000_0013);
      check_eq("l2_w0_rdy", {31'b0, wq_rdy[0]}, 32'd1);
      check_eq("l2_w1_addr", {26'b0, wq_addr[1]}, 32'd1);
      check_eq("l2_w1_data", wq_data[1], 32'h0010_0093);
      check_eq("l2_w1_rdy", {31'b0, wq_rdy[1]}, 32'd0);
    end

    // Rejected length while running
    start_load(7'd0);
    check_eq("run_bad_error", {31'b0, error}, 32'd1);
    check_eq("run_bad_done", {31'b0, done}, 32'd1);
    cyc();
    check_eq("run_bad_core_reset", {31'b0, core_reset}, 32'd0);

    // Full-depth load with random data and gaps, restarted from RUN
    clear_wq();
    prog.delete();
    for (int i = 0; i < DEPTH * 4; i++) prog.push_back(8'($urandom));
    start_load(7'd64);
    check_eq("l64_core_reset", {31'b0, core_reset}, 32'd1);
    check_eq("l64_done", {31'b0, done}, 32'd0);
    send_prog(2);
    finish_load();
    check_eq("l64_done_run", {31'b0, done}, 32'd1);
    repeat (3) cyc();
    check_eq("l64_nwrites", wq_addr.size(), 32'd64);
    if (wq_addr.size() == 64) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_w = {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
        check_eq($sformatf("l64_addr%0d", i), {26'b0, wq_addr[i]}, i);
        check_eq($sformatf("l64_data%0d", i), wq_data[i], exp_w);
      end
    end

    // Asynchronous reset in the middle of a load
    start_load(7'd4);
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_prog(0);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_core_reset", {31'b0, core_reset}, 32'd1);
    check_eq("mid_rst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    check_eq("mid_rst_imem_we", {31'b0, bus.imem_we}, 32'd0);
    check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'b0, done}, 32'd0);
    clear_wq();
    cyc();
    reset = 1'b0;
    cyc();
    start_load(7'd1);
    prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_prog(0);
    finish_load();
    check_eq("post_rst_done", {31'b0, done}, 32'd1);
    check_eq("post_rst_nwrites", wq_addr.size(), 32'd1);
    if (wq_addr.size() == 1) begin
      check_eq("post_rst_addr", {26'b0, wq_addr[0]}, 32'd0);
      check_eq("post_rst_data", wq_data[0], 32'hDDCC_BBAA);
    end

`ifdef LOADER_CHECKSUM_EN
    // Good checksum: 01+02+03+04+F6 = 0x100
    start_load(7'd1);
    prog = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_prog(0);
    send_byte(8'hF6, 0);
    cyc();
    check_eq("cs_good_done", {31'b0, done}, 32'd1);
    check_eq("cs_good_core_reset", {31'b0, core_reset}, 32'd0);

    // Bad checksum: sum 0xFF
    start_load(7'd1);
    send_prog(0);
    send_byte(8'hF5, 0);
    check_eq("cs_bad_error", {31'b0, error}, 32'd1);
    check_eq("cs_bad_core_reset", {31'b0, core_reset}, 32'd1);
    check_eq("cs_bad_done", {31'b0, done}, 32'd0);
    cyc();
    check_eq("cs_bad_error_clr", {31'b0, error}, 32'd0);
    check_eq("cs_bad_idle_done", {31'b0, done}, 32'd0);
    check_eq("cs_bad_idle_rdy", {31'b0, bus.rx_ready}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
